// File: rtl/fast_vram_arb_if.sv
// Bus bundle between the fast VRAM arbiter, its two requesters (video fetch
// and CPU register port) and the pair of 2K x 8 RAM chips.
// slave  : arbiter view
// master : environment view (requesters plus RAM)
interface fast_vram_arb_if #(
  parameter int ADDR_W = 11
);
  // Video fetch requester
  logic              VID_REQ;
  logic [ADDR_W-1:0] VID_ADDR;
  logic              VID_ACK;
  logic [15:0]       VID_DATA;

  // CPU register port
  logic              CPU_ADDR_WE;
  logic              CPU_MOD_WE;
  logic              CPU_DATA_WE;
  logic              CPU_RD;
  logic [15:0]       CPU_DIN;
  logic [15:0]       CPU_DOUT;
  logic              CPU_BUSY;

  // RAM side
  logic [ADDR_W-1:0] FV_ADDR;
  logic [15:0]       FV_DOUT;
  logic              FV_DOE;
  logic [15:0]       FV_DIN;
  logic              nFV_CE;
  logic              nFV_OE;
  logic              nFV_WE;

  modport slave (
    input  VID_REQ, VID_ADDR,
    input  CPU_ADDR_WE, CPU_MOD_WE, CPU_DATA_WE, CPU_RD, CPU_DIN,
    input  FV_DIN,
    output VID_ACK, VID_DATA,
    output CPU_DOUT, CPU_BUSY,
    output FV_ADDR, FV_DOUT, FV_DOE, nFV_CE, nFV_OE, nFV_WE
  );

  modport master (
    output VID_REQ, VID_ADDR,
    output CPU_ADDR_WE, CPU_MOD_WE, CPU_DATA_WE, CPU_RD, CPU_DIN,
    output FV_DIN,
    input  VID_ACK, VID_DATA,
    input  CPU_DOUT, CPU_BUSY,
    input  FV_ADDR, FV_DOUT, FV_DOE, nFV_CE, nFV_OE, nFV_WE
  );
endinterface

// File: rtl/fast_vram_arb.sv
// Fast VRAM arbiter and access sequencer.
// Video reads win arbitration; CPU writes are posted through a one-entry
// buffer and advance the address register by the modulo when they finish.
// Every RAM-side output comes straight from a flop: strobe levels are
// decoded from the state being entered and registered with the state.
module fast_vram_arb #(
  parameter int                ADDR_W    = 11,
  parameter logic [ADDR_W-1:0] MOD_RESET = {{(ADDR_W-1){1'b0}}, 1'b1}
) (
  input logic            CLK_24M,
  input logic            RESET,
  fast_vram_arb_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    VRD1,
    VRD2,
    CRD1,
    CRD2,
    CWR1,
    CWR2,
    CWR3,
    TURN
  } state_t;

  state_t state_q, state_d;

  // Registered RAM strobes (active low) and data driver enable
  logic nce_q, nce_d;
  logic noe_q, noe_d;
  logic nwe_q, nwe_d;
  logic doe_q, doe_d;
  logic [ADDR_W-1:0] fv_addr_q, fv_addr_d;

  // CPU register port state
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mod_q, mod_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              pend_wr_q, pend_wr_d;
  logic              pend_rd_q, pend_rd_d;
  logic [15:0]       cpu_dout_q, cpu_dout_d;

  // Video return path
  logic [15:0] vid_data_q, vid_data_d;
  logic        vid_ack_q, vid_ack_d;

  // A pending request stays set until its access completes, so it also
  // covers the in-progress phase.
  logic cpu_free;
  assign cpu_free = ~(pend_wr_q | pend_rd_q);

  // State register
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state arbitration and strobe decode for the state being entered
  always_comb begin
    state_d = state_q;
    nce_d   = 1'b1;
    noe_d   = 1'b1;
    nwe_d   = 1'b1;
    doe_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.VID_REQ) begin
          state_d = VRD1;
        end else if (pend_rd_q) begin
          state_d = CRD1;
        end else if (pend_wr_q) begin
          state_d = CWR1;
        end
      end
      VRD1:    state_d = VRD2;
      VRD2:    state_d = TURN;
      CRD1:    state_d = CRD2;
      CRD2:    state_d = TURN;
      CWR1:    state_d = CWR2;
      CWR2:    state_d = CWR3;
      CWR3:    state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Output enable is only ever asserted in read states, so it can never
    // overlap a write pulse or the data driver.
    case (state_d)
      VRD1, VRD2, CRD1, CRD2: begin
        nce_d = 1'b0;
        noe_d = 1'b0;
      end
      CWR1, CWR3: begin
        nce_d = 1'b0;
        doe_d = 1'b1;
      end
      CWR2: begin
        nce_d = 1'b0;
        nwe_d = 1'b0;
        doe_d = 1'b1;
      end
      default: ;
    endcase
  end

  // CPU register updates, data capture and RAM address selection
  always_comb begin
    addr_d     = addr_q;
    mod_d      = mod_q;
    wdata_d    = wdata_q;
    pend_wr_d  = pend_wr_q;
    pend_rd_d  = pend_rd_q;
    cpu_dout_d = cpu_dout_q;
    vid_data_d = vid_data_q;
    fv_addr_d  = fv_addr_q;
    vid_ack_d  = (state_q == VRD2);

    // Strobes arriving while busy are dropped; a write beats a read
    if (cpu_free) begin
      if (bus.CPU_ADDR_WE) addr_d = bus.CPU_DIN[ADDR_W-1:0];
      if (bus.CPU_MOD_WE)  mod_d  = bus.CPU_DIN[ADDR_W-1:0];
      if (bus.CPU_DATA_WE) begin
        pend_wr_d = 1'b1;
        wdata_d   = bus.CPU_DIN;
      end else if (bus.CPU_RD) begin
        pend_rd_d = 1'b1;
      end
    end

    case (state_q)
      VRD2: vid_data_d = bus.FV_DIN;
      CRD2: begin
        cpu_dout_d = bus.FV_DIN;
        pend_rd_d  = 1'b0;
      end
      CWR3: begin
        addr_d    = addr_q + mod_q;   // carry out discarded: wraps at 2048
        pend_wr_d = 1'b0;
      end
      default: ;
    endcase

    case (state_d)
      VRD1, VRD2:                   fv_addr_d = bus.VID_ADDR;
      CRD1, CRD2, CWR1, CWR2, CWR3: fv_addr_d = addr_q;
      default: ;
    endcase
  end

  // Datapath and registered output flops
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      nce_q      <= 1'b1;
      noe_q      <= 1'b1;
      nwe_q      <= 1'b1;
      doe_q      <= 1'b0;
      fv_addr_q  <= '0;
      addr_q     <= '0;
      mod_q      <= MOD_RESET;
      wdata_q    <= '0;
      pend_wr_q  <= 1'b0;
      pend_rd_q  <= 1'b0;
      cpu_dout_q <= '0;
      vid_data_q <= '0;
      vid_ack_q  <= 1'b0;
    end else begin
      nce_q      <= nce_d;
      noe_q      <= noe_d;
      nwe_q      <= nwe_d;
      doe_q      <= doe_d;
      fv_addr_q  <= fv_addr_d;
      addr_q     <= addr_d;
      mod_q      <= mod_d;
      wdata_q    <= wdata_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      cpu_dout_q <= cpu_dout_d;
      vid_data_q <= vid_data_d;
      vid_ack_q  <= vid_ack_d;
    end
  end

  assign bus.nFV_CE   = nce_q;
  assign bus.nFV_OE   = noe_q;
  assign bus.nFV_WE   = nwe_q;
  assign bus.FV_DOE   = doe_q;
  assign bus.FV_ADDR  = fv_addr_q;
  assign bus.FV_DOUT  = wdata_q;    // write buffer is stable for the whole write
  assign bus.VID_ACK  = vid_ack_q;
  assign bus.VID_DATA = vid_data_q;
  assign bus.CPU_DOUT = cpu_dout_q;
  assign bus.CPU_BUSY = pend_wr_q | pend_rd_q;

endmodule

// File: tb/tb_fast_vram_arb.sv
// Directed bench for fast_vram_arb with a simple RAM model on the chip bus.
`timescale 1ns/1ps
module tb_fast_vram_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #21 clk = ~clk;

  fast_vram_arb_if #(.ADDR_W(11)) bus();

  fast_vram_arb #(.ADDR_W(11), .MOD_RESET(11'd1)) dut (
    .CLK_24M (clk),
    .RESET   (rst),
    .bus     (bus)
  );

  // RAM model: asynchronous read while CE and OE are low, write on a clock
  // where CE and WE are low with the data driver enabled.
  logic [15:0] mem [0:2047];
  logic        init_done = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int          we_low = 0;
  int          oe_low = 0;
  int          oe_bad = 0;
  int          wr_cnt = 0;

  assign bus.FV_DIN = (!bus.nFV_CE && !bus.nFV_OE) ? mem[bus.FV_ADDR] : 16'hFFFF;

  // RAM contents, write capture and strobe activity counters
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 16'h0000;
      mem[11'h011] <= 16'h0BAD;
      mem[11'h7FE] <= 16'h7E7E;
      mem[11'h123] <= 16'h5A5A;
      mem[11'h200] <= 16'h2002;
    end else begin
      if (!bus.nFV_WE) we_low <= we_low + 1;
      if (!bus.nFV_OE) oe_low <= oe_low + 1;
      if (!bus.nFV_OE && (!bus.nFV_WE || bus.FV_DOE)) oe_bad <= oe_bad + 1;
      if (!bus.nFV_CE && !bus.nFV_WE && bus.FV_DOE) begin
        mem[bus.FV_ADDR] <= bus.FV_DOUT;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu(input logic aw, input logic mw, input logic dw, input logic rd,
                     input logic [15:0] din);
    bus.CPU_ADDR_WE = aw;
    bus.CPU_MOD_WE  = mw;
    bus.CPU_DATA_WE = dw;
    bus.CPU_RD      = rd;
    bus.CPU_DIN     = din;
    tick();
    bus.CPU_ADDR_WE = 1'b0;
    bus.CPU_MOD_WE  = 1'b0;
    bus.CPU_DATA_WE = 1'b0;
    bus.CPU_RD      = 1'b0;
  endtask

  task automatic wait_free;
    for (int i = 0; i < 16 && bus.CPU_BUSY; i++) tick();
    chk("busy_timeout", 16'(bus.CPU_BUSY), 16'h0000);
  endtask

  // CPU read: checks address driven in CRD1 and the returned word
  task automatic rd_addr(input string tag, input logic [10:0] a, input logic [15:0] d);
    cpu(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    chk({tag, "_rd_addr"}, 16'(bus.FV_ADDR), 16'(a));
    chk({tag, "_rd_oe"}, 16'(bus.nFV_OE), 16'h0000);
    tick();
    tick();
    chk({tag, "_rd_data"}, bus.CPU_DOUT, d);
    chk({tag, "_rd_busy"}, 16'(bus.CPU_BUSY), 16'h0000);
  endtask

  int w0;
  int o0;

  initial begin
    bus.VID_REQ     = 1'b0;
    bus.VID_ADDR    = '0;
    bus.CPU_ADDR_WE = 1'b0;
    bus.CPU_MOD_WE  = 1'b0;
    bus.CPU_DATA_WE = 1'b0;
    bus.CPU_RD      = 1'b0;
    bus.CPU_DIN     = '0;
    rst = 1'b1;
    tick();
    init_done = 1'b1;
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_nce",  16'(bus.nFV_CE), 16'h0001);
    chk("rst_noe",  16'(bus.nFV_OE), 16'h0001);
    chk("rst_nwe",  16'(bus.nFV_WE), 16'h0001);
    chk("rst_doe",  16'(bus.FV_DOE), 16'h0000);
    chk("rst_addr", 16'(bus.FV_ADDR), 16'h0000);
    chk("rst_dout", bus.FV_DOUT, 16'h0000);
    chk("rst_ack",  16'(bus.VID_ACK), 16'h0000);
    chk("rst_vdat", bus.VID_DATA, 16'h0000);
    chk("rst_cdat", bus.CPU_DOUT, 16'h0000);
    chk("rst_busy", 16'(bus.CPU_BUSY), 16'h0000);

    // T1: posted write with strobe sequence, then read at incremented address
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
    cpu(1'b0, 1'b1, 1'b0, 1'b0, 16'h0001);
    w0 = we_low;
    cpu(1'b0, 1'b0, 1'b1, 1'b0, 16'hABCD);
    chk("t1_busy", 16'(bus.CPU_BUSY), 16'h0001);
    chk("t1_idle_ce", 16'(bus.nFV_CE), 16'h0001);
    tick();
    chk("t1_cwr1_doe", 16'(bus.FV_DOE), 16'h0001);
    chk("t1_cwr1_we",  16'(bus.nFV_WE), 16'h0001);
    chk("t1_cwr1_ce",  16'(bus.nFV_CE), 16'h0000);
    chk("t1_cwr1_adr", 16'(bus.FV_ADDR), 16'h0010);
    chk("t1_cwr1_dat", bus.FV_DOUT, 16'hABCD);
    tick();
    chk("t1_cwr2_we",  16'(bus.nFV_WE), 16'h0000);
    chk("t1_cwr2_doe", 16'(bus.FV_DOE), 16'h0001);
    tick();
    chk("t1_cwr3_we",  16'(bus.nFV_WE), 16'h0001);
    chk("t1_cwr3_doe", 16'(bus.FV_DOE), 16'h0001);
    tick();
    chk("t1_turn_doe", 16'(bus.FV_DOE), 16'h0000);
    chk("t1_turn_ce",  16'(bus.nFV_CE), 16'h0001);
    chk("t1_turn_busy", 16'(bus.CPU_BUSY), 16'h0000);
    chk("t1_ram", mem[11'h010], 16'hABCD);
    chk("t1_we_pulse", 16'(we_low - w0), 16'h0001);
    rd_addr("t1", 11'h011, 16'h0BAD);

    // T2: modulo 0x7FF acts as -1 with wrap below zero
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cpu(1'b0, 1'b1, 1'b0, 1'b0, 16'h07FF);
    cpu(1'b0, 1'b0, 1'b1, 1'b0, 16'h1111);
    wait_free();
    cpu(1'b0, 1'b0, 1'b1, 1'b0, 16'h2222);
    wait_free();
    chk("t2_ram0",   mem[11'h000], 16'h1111);
    chk("t2_ram7ff", mem[11'h7FF], 16'h2222);
    rd_addr("t2", 11'h7FE, 16'h7E7E);

    // T3: address+modulo+data in one cycle, then data+read in one cycle
    cpu(1'b1, 1'b1, 1'b1, 1'b0, 16'h0005);
    wait_free();
    chk("t3_ram5", mem[11'h005], 16'h0005);
    o0 = oe_low;
    w0 = wr_cnt;
    cpu(1'b0, 1'b0, 1'b1, 1'b1, 16'h00AA);
    wait_free();
    chk("t3_ramA", mem[11'h00A], 16'h00AA);
    chk("t3_no_read", 16'(oe_low - o0), 16'h0000);
    chk("t3_one_wr", 16'(wr_cnt - w0), 16'h0001);
    rd_addr("t3", 11'h00F, 16'h0000);

    // T4: video request beats a pending write in the same IDLE cycle
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 16'h0300);
    bus.CPU_DATA_WE = 1'b1;
    bus.CPU_DIN     = 16'h3333;
    tick();
    bus.CPU_DATA_WE = 1'b0;
    bus.VID_REQ     = 1'b1;
    bus.VID_ADDR    = 11'h200;
    tick();
    chk("t4_vrd1_adr", 16'(bus.FV_ADDR), 16'h0200);
    chk("t4_vrd1_oe",  16'(bus.nFV_OE), 16'h0000);
    chk("t4_vrd1_ack", 16'(bus.VID_ACK), 16'h0000);
    chk("t4_vrd1_busy", 16'(bus.CPU_BUSY), 16'h0001);
    tick();
    chk("t4_vrd2_ack", 16'(bus.VID_ACK), 16'h0000);
    tick();
    chk("t4_ack",  16'(bus.VID_ACK), 16'h0001);
    chk("t4_vdat", bus.VID_DATA, 16'h2002);
    chk("t4_turn_busy", 16'(bus.CPU_BUSY), 16'h0001);
    bus.VID_REQ = 1'b0;
    tick();
    chk("t4_ack_drop", 16'(bus.VID_ACK), 16'h0000);
    chk("t4_idle_busy", 16'(bus.CPU_BUSY), 16'h0001);
    tick();
    chk("t4_cwr1_doe", 16'(bus.FV_DOE), 16'h0001);
    chk("t4_cwr1_adr", 16'(bus.FV_ADDR), 16'h0300);
    chk("t4_cwr1_busy", 16'(bus.CPU_BUSY), 16'h0001);
    wait_free();
    chk("t4_ram", mem[11'h300], 16'h3333);

    // T5: CPU read leaves the address unchanged and never pulses WE
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 16'h0123);
    w0 = we_low;
    rd_addr("t5a", 11'h123, 16'h5A5A);
    rd_addr("t5b", 11'h123, 16'h5A5A);
    chk("t5_no_we", 16'(we_low - w0), 16'h0000);

    // T6: strobes while busy are ignored
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 16'h0050);
    cpu(1'b0, 1'b1, 1'b0, 1'b0, 16'h0001);
    w0 = wr_cnt;
    cpu(1'b0, 1'b0, 1'b1, 1'b0, 16'h6666);
    cpu(1'b1, 1'b0, 1'b1, 1'b0, 16'h0777);
    wait_free();
    chk("t6_ram50", mem[11'h050], 16'h6666);
    chk("t6_ram51", mem[11'h051], 16'h0000);
    chk("t6_one_wr", 16'(wr_cnt - w0), 16'h0001);
    rd_addr("t6", 11'h051, 16'h0000);

    // T7: reset in the middle of a write
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 16'h0400);
    cpu(1'b0, 1'b1, 1'b0, 1'b0, 16'h0003);
    cpu(1'b0, 1'b0, 1'b1, 1'b0, 16'hDEAD);
    tick();
    tick();
    chk("t7_cwr2_we", 16'(bus.nFV_WE), 16'h0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_nce",  16'(bus.nFV_CE), 16'h0001);
    chk("t7_noe",  16'(bus.nFV_OE), 16'h0001);
    chk("t7_nwe",  16'(bus.nFV_WE), 16'h0001);
    chk("t7_doe",  16'(bus.FV_DOE), 16'h0000);
    chk("t7_busy", 16'(bus.CPU_BUSY), 16'h0000);
    chk("t7_ack",  16'(bus.VID_ACK), 16'h0000);
    cpu(1'b0, 1'b0, 1'b1, 1'b0, 16'h4444);
    wait_free();
    cpu(1'b0, 1'b0, 1'b1, 1'b0, 16'h5555);
    wait_free();
    chk("t7_ram0", mem[11'h000], 16'h4444);
    chk("t7_ram1", mem[11'h001], 16'h5555);
    rd_addr("t7", 11'h002, 16'h0000);

    chk("oe_exclusive", 16'(oe_bad), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
